ascii_num_buffer: RTL and testbench

Receive-side counterpart of the ASCII number stream: consumes UART RX bytes, parses signed decimal integers and stores them in a small indexed buffer. The matrix operation selector and other consumers read it through `rd_addr`/`rd_data`/`num_count` and empty it with `clear`. It sits between the UART receiver and every block that takes numeric console input, such as dimensions, matrix IDs and scalars.

---
 rtl/ascii_num_buffer_pkg.sv | 30 +++
 rtl/ascii_num_buffer_dec.sv | 20 ++
 rtl/ascii_num_buffer.sv | 164 ++++++++++++++++
 tb/tb_ascii_num_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ascii_num_buffer_pkg.sv
// Shared types and character constants for the ASCII number receive buffer.
package ascii_num_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SIGN,
    DIGITS,
    DISCARD
  } parse_state_t;

  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  // Largest magnitude kept; 2^31 is the only value that fits negative but not positive.
  localparam logic [35:0] MAG_LIMIT = 36'h0_8000_0000;

  function automatic logic is_sep_char(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_COMMA) || (c == CH_CR) || (c == CH_LF);
  endfunction

  function automatic logic is_digit_char(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/ascii_num_buffer_dec.sv
// Decimal accumulate step: mag*10 + d with saturation at MAG_LIMIT.
module dec_digit_acc
  import ascii_num_buffer_pkg::*;
(
  input  logic [31:0] mag,
  input  logic [3:0]  digit,
  output logic [31:0] next_mag,
  output logic        sat
);

  logic [35:0] wide;

  // Shift-add multiply by ten; 36 bits cannot overflow since mag never exceeds 2^31.
  always_comb begin
    wide     = ({4'd0, mag} << 3) + ({4'd0, mag} << 1) + {32'd0, digit};
    sat      = (wide > MAG_LIMIT);
    next_mag = sat ? MAG_LIMIT[31:0] : wide[31:0];
  end

endmodule

// File: rtl/ascii_num_buffer.sv
// Parses signed decimal integers from a UART byte stream into a small
// zero-on-clear register buffer read through rd_addr/rd_data.
//
// state   | meaning
// IDLE    | between tokens, waiting for a digit or minus
// SIGN    | minus seen, waiting for the first digit
// DIGITS  | accumulating magnitude of the current token
// DISCARD | malformed token, skipping until a separator
module ascii_num_buffer
  import ascii_num_buffer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   flush,
  input  logic                   clear,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [31:0]            rd_data,
  output logic [COUNT_WIDTH-1:0] num_count,
  output logic                   fmt_err,
  output logic                   range_err,
  output logic                   full_err
);

  parse_state_t state;
  logic [31:0]  mag;
  logic         neg;
  logic [31:0]  entries [DEPTH];

  logic         is_digit;
  logic         is_minus;
  logic         is_sep;
  logic [3:0]   digit;
  logic [31:0]  acc_next;
  logic         acc_sat;

  logic         commit_en;
  logic         commit_sat;
  logic [31:0]  commit_val;
  logic         has_room;
  logic         wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic         rd_hit;
  logic         rd_fwd;

  dec_digit_acc u_acc (
    .mag      (mag),
    .digit    (digit),
    .next_mag (acc_next),
    .sat      (acc_sat)
  );

  // Byte classification and commit value selection.
  always_comb begin
    is_digit  = is_digit_char(rx_data);
    is_minus  = (rx_data == CH_MINUS);
    is_sep    = is_sep_char(rx_data);
    digit     = rx_data[3:0];

    commit_en = (state == DIGITS) && !clear && (flush || (rx_valid && is_sep));
    commit_sat = 1'b0;
    if (neg) begin
      commit_val = -mag;
    end else if ({4'd0, mag} == MAG_LIMIT) begin
      commit_val = 32'h7FFF_FFFF;
      commit_sat = commit_en;
    end else begin
      commit_val = mag;
    end

    has_room = (num_count < COUNT_WIDTH'(DEPTH));
    wr_en    = commit_en && has_room;
    wr_idx   = num_count[ADDR_WIDTH-1:0];
    rd_hit   = (COUNT_WIDTH'(rd_addr) < num_count);
    rd_fwd   = wr_en && (COUNT_WIDTH'(rd_addr) == num_count);
  end

  // Token parser FSM; clear beats flush, flush beats an incoming byte.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state     <= IDLE;
      mag       <= '0;
      neg       <= 1'b0;
      fmt_err   <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (commit_sat) range_err <= 1'b1;
      if (flush) begin
        state <= IDLE;
      end else if (rx_valid) begin
        unique case (state)
          IDLE: begin
            if (is_digit) begin
              state <= DIGITS;
              mag   <= {28'd0, digit};
              neg   <= 1'b0;
            end else if (is_minus) begin
              state <= SIGN;
              mag   <= '0;
              neg   <= 1'b1;
            end else if (!is_sep) begin
              state   <= DISCARD;
              fmt_err <= 1'b1;
            end
          end
          SIGN: begin
            if (is_digit) begin
              state <= DIGITS;
              mag   <= {28'd0, digit};
            end else if (is_sep) begin
              state <= IDLE;
            end else begin
              state   <= DISCARD;
              fmt_err <= 1'b1;
            end
          end
          DIGITS: begin
            if (is_digit) begin
              mag <= acc_next;
              if (acc_sat) range_err <= 1'b1;
            end else if (is_sep) begin
              state <= IDLE;
            end else begin
              state   <= DISCARD;
              fmt_err <= 1'b1;
            end
          end
          DISCARD: begin
            if (is_sep) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Entry storage, fill count and write-first registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      num_count <= '0;
      full_err  <= 1'b0;
      rd_data   <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (commit_en) begin
        if (has_room) begin
          entries[wr_idx] <= commit_val;
          num_count       <= num_count + COUNT_WIDTH'(1);
        end else begin
          full_err <= 1'b1;
        end
      end
      if (rd_fwd) rd_data <= commit_val;
      else if (rd_hit) rd_data <= entries[rd_addr];
      else rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_ascii_num_buffer.sv
// Directed self-checking bench for ascii_num_buffer.
module tb_ascii_num_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        flush = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [31:0] rd_data;
  logic [10:0] num_count;
  logic        fmt_err;
  logic        range_err;
  logic        full_err;

  int n_cmp = 0;
  int n_err = 0;

  ascii_num_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .flush     (flush),
    .clear     (clear),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .num_count (num_count),
    .fmt_err   (fmt_err),
    .range_err (range_err),
    .full_err  (full_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    rd_addr = addr;
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  task automatic check_flags(input string tag, input logic f, input logic r, input logic u);
    check({tag, "_fmt"},   32'(fmt_err),   32'(f));
    check({tag, "_range"}, 32'(range_err), 32'(r));
    check({tag, "_full"},  32'(full_err),  32'(u));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_count", 32'(num_count), 32'd0);
    check("rst_rdata", rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_flags("rst", 1'b0, 1'b0, 1'b0);

    // Basic positive/negative tokens
    send_str("12 -7\n");
    check("basic_count", 32'(num_count), 32'd2);
    read_check("basic_0", 4'd0, 32'h0000_000C);
    read_check("basic_1", 4'd1, 32'hFFFF_FFF9);
    read_check("basic_2_unused", 4'd2, 32'h0);
    check_flags("basic", 1'b0, 1'b0, 1'b0);

    // Range boundary values
    pulse_clear();
    send_str("-1,");
    read_check("neg1", 4'd0, 32'hFFFF_FFFF);
    check("neg1_range", 32'(range_err), 32'd0);
    send_str("2147483648 -2147483648 ");
    read_check("pos_sat", 4'd1, 32'h7FFF_FFFF);
    check("pos_sat_range", 32'(range_err), 32'd1);
    read_check("neg_min", 4'd2, 32'h8000_0000);
    check("range_count", 32'(num_count), 32'd3);

    // Accumulator overflow saturates, negative side
    pulse_clear();
    check("clear_range", 32'(range_err), 32'd0);
    send_str("-99999999999 ");
    read_check("neg_ovf", 4'd0, 32'h8000_0000);
    check("neg_ovf_range", 32'(range_err), 32'd1);

    // Buffer full
    pulse_clear();
    for (int i = 0; i < 17; i++) send_str("5 ");
    check("full_count", 32'(num_count), 32'd16);
    check("full_err", 32'(full_err), 32'd1);
    read_check("full_15", 4'd15, 32'd5);
    pulse_clear();
    read_check("clear_15", 4'd15, 32'd0);
    check("clear_count", 32'(num_count), 32'd0);
    check("clear_full", 32'(full_err), 32'd0);

    // Malformed tokens and flush commit
    send_str("1a2 3 - ,4");
    pulse_flush();
    check("fmt_count", 32'(num_count), 32'd2);
    check("fmt_err", 32'(fmt_err), 32'd1);
    read_check("fmt_0", 4'd0, 32'd3);
    read_check("fmt_1", 4'd1, 32'd4);

    // Clear coinciding with a separator in DIGITS
    pulse_clear();
    send_str("9");
    rx_data  = 8'h20;
    rx_valid = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    clear    = 1'b0;
    check("clr_sep_count", 32'(num_count), 32'd0);
    send_str("6 ");
    check("clr_sep_count2", 32'(num_count), 32'd1);
    read_check("clr_sep_idle", 4'd0, 32'd6);

    // Flush coinciding with a byte: commit, drop byte
    pulse_clear();
    send_str("7");
    rx_data  = 8'h38;
    rx_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    flush    = 1'b0;
    check("flush_rx_count", 32'(num_count), 32'd1);
    send_str("2 ");
    read_check("flush_rx_0", 4'd0, 32'd7);
    read_check("flush_rx_1", 4'd1, 32'd2);

    // Write-first read of the entry being committed
    pulse_clear();
    rd_addr = 4'd0;
    send_str("4");
    send_byte(8'h20);
    check("write_first", rd_data, 32'd4);

    // Reset mid-token
    pulse_clear();
    send_str("88");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_str(" 3 ");
    check("rst_mid_count", 32'(num_count), 32'd1);
    read_check("rst_mid_0", 4'd0, 32'd3);
    check_flags("end", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
